// File: rtl/vita49_pkg.sv
// Shared types and field indices for the VITA-49 transmit run sequencer.
// State encoding, packer ctrl bits, command bits and source command codes.
package vita49_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int CTRL_START = 0;
  localparam int CTRL_RST   = 1;
  localparam int CTRL_PASS  = 2;
  localparam int CTRL_TRL   = 3;
  localparam int CTRL_TSI   = 4;

  localparam int CMD_ARM   = 0;
  localparam int CMD_ABORT = 1;
  localparam int CMD_IMM   = 2;
  localparam int CMD_TRL   = 3;
  localparam int CMD_TSI   = 4;
  localparam int CMD_PASS  = 5;

  localparam logic [31:0] SRC_IDLE = 32'd0;
  localparam logic [31:0] SRC_RUN  = 32'd1;
  localparam logic [31:0] SRC_RST  = 32'd2;

endpackage

// File: rtl/vita49_seq_ctrl_if.sv
// Monitor tap on the packer egress AXI-stream handshake.
// master: the side driving the stream; slave: the passive observer.
interface vita49_seq_ctrl_if;
  logic vita_tvalid;
  logic vita_tready;
  logic vita_tlast;

  modport master (
    output vita_tvalid,
    output vita_tready,
    output vita_tlast
  );

  modport slave (
    input vita_tvalid,
    input vita_tready,
    input vita_tlast
  );
endinterface

// File: rtl/vita49_time_cmp.sv
// Registered 96-bit unsigned compare: ge = {a_sec,a_fsec} >= {b_sec,b_fsec}.
// Ports: clk/rst_n, a_* current time, b_* threshold, ge one cycle later.
module vita49_time_cmp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a_sec,
  input  logic [63:0] a_fsec,
  input  logic [31:0] b_sec,
  input  logic [63:0] b_fsec,
  output logic        ge
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ge <= 1'b0;
    else        ge <= {a_sec, a_fsec} >= {b_sec, b_fsec};
  end

endmodule

// File: rtl/vita49_seq_ctrl.sv
// VITA-49 transmit run sequencer: reset pulse, timed/immediate start, packet
// count and shutdown. Ports: AXIS_ACLK/AXIS_ARESETN, cmd bus, start time,
// num_pkts, current time, egress tap; vita_ctrl, src_cmd, pkt_count, status.
module vita49_seq_ctrl
  import vita49_pkg::*;
#(
  parameter int RST_CYCLES = 4
) (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESETN,
  input  logic [31:0] cmd,
  input  logic        cmd_valid,
  input  logic [31:0] start_sec,
  input  logic [63:0] start_fsec,
  input  logic [31:0] num_pkts,
  input  logic [31:0] timestamp_sec,
  input  logic [63:0] timestamp_fsec,
  vita49_seq_ctrl_if.slave egress,
  output logic [31:0] vita_ctrl,
  output logic [31:0] src_cmd,
  output logic        src_new_cmd,
  output logic [31:0] pkt_count,
  output logic [31:0] status,
  output logic        done_pulse
);

  localparam int CW = $clog2(RST_CYCLES + 1);

  state_e      state;
  logic [CW-1:0] rst_cnt;
  logic [31:0] start_sec_q;
  logic [63:0] start_fsec_q;
  logic [31:0] num_q;
  logic        imm_q;
  logic        trl_q;
  logic        tsi_q;
  logic        pass_q;
  logic        first_wait;
  logic        late_q;
  logic        done_q;
  logic        ts_ge;
  logic        hs;
  logic        arm;
  logic        abort;
  logic        last_pkt;
  logic        finish;
  logic [31:0] run_ctrl;
  logic        unused_cmd;

  assign unused_cmd = ^cmd[31:6];

  vita49_time_cmp u_cmp (
    .clk    (AXIS_ACLK),
    .rst_n  (AXIS_ARESETN),
    .a_sec  (timestamp_sec),
    .a_fsec (timestamp_fsec),
    .b_sec  (start_sec_q),
    .b_fsec (start_fsec_q),
    .ge     (ts_ge)
  );

  assign hs = egress.vita_tvalid
            & egress.vita_tready
            & egress.vita_tlast;

  // Abort beats arm; arm only counts from IDLE.
  assign abort = cmd_valid & cmd[CMD_ABORT]
               & (state inside {ST_RESET, ST_WAIT, ST_RUN});
  assign arm   = cmd_valid & cmd[CMD_ARM]
               & ~cmd[CMD_ABORT] & (state == ST_IDLE);

  assign last_pkt = (state == ST_RUN) & hs
                  & (num_q != 32'd0)
                  & ((pkt_count + 32'd1) == num_q);

  assign finish = abort | last_pkt;

  always_comb begin
    run_ctrl             = '0;
    run_ctrl[CTRL_START] = 1'b1;
    run_ctrl[CTRL_PASS]  = pass_q;
    run_ctrl[CTRL_TRL]   = trl_q;
    run_ctrl[CTRL_TSI]   = tsi_q;
  end

  assign status = {26'd0, done_q, late_q,
                   state != ST_IDLE, state};

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state        <= ST_IDLE;
      rst_cnt      <= '0;
      start_sec_q  <= '0;
      start_fsec_q <= '0;
      num_q        <= '0;
      imm_q        <= 1'b0;
      trl_q        <= 1'b0;
      tsi_q        <= 1'b0;
      pass_q       <= 1'b0;
      first_wait   <= 1'b0;
      late_q       <= 1'b0;
      done_q       <= 1'b0;
      vita_ctrl    <= '0;
      src_cmd      <= SRC_IDLE;
      src_new_cmd  <= 1'b0;
      done_pulse   <= 1'b0;
    end else begin
      src_new_cmd <= 1'b0;
      done_pulse  <= 1'b0;
      if (finish) begin
        state       <= ST_DONE;
        vita_ctrl   <= '0;
        src_cmd     <= SRC_IDLE;
        src_new_cmd <= 1'b1;
        done_pulse  <= 1'b1;
        done_q      <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE: begin
            vita_ctrl <= '0;
            if (arm) begin
              state               <= ST_RESET;
              start_sec_q         <= start_sec;
              start_fsec_q        <= start_fsec;
              num_q               <= num_pkts;
              imm_q               <= cmd[CMD_IMM];
              trl_q               <= cmd[CMD_TRL];
              tsi_q               <= cmd[CMD_TSI];
              pass_q              <= cmd[CMD_PASS];
              late_q              <= 1'b0;
              done_q              <= 1'b0;
              rst_cnt             <= CW'(1);
              vita_ctrl           <= '0;
              vita_ctrl[CTRL_RST] <= 1'b1;
              src_cmd             <= SRC_RST;
              src_new_cmd         <= 1'b1;
            end
          end
          ST_RESET: begin
            if (rst_cnt == CW'(RST_CYCLES)) begin
              if (imm_q) begin
                state       <= ST_RUN;
                vita_ctrl   <= run_ctrl;
                src_cmd     <= SRC_RUN;
                src_new_cmd <= 1'b1;
              end else begin
                state      <= ST_WAIT;
                vita_ctrl  <= '0;
                first_wait <= 1'b1;
              end
            end else begin
              rst_cnt <= rst_cnt + CW'(1);
            end
          end
          ST_WAIT: begin
            first_wait <= 1'b0;
            if (ts_ge) begin
              // Already past the start time on the first look: late.
              late_q      <= first_wait;
              state       <= ST_RUN;
              vita_ctrl   <= run_ctrl;
              src_cmd     <= SRC_RUN;
              src_new_cmd <= 1'b1;
            end
          end
          ST_RUN: begin
            vita_ctrl <= run_ctrl;
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Abort freezes the count; otherwise saturating count of TLAST handshakes.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      pkt_count <= '0;
    end else if (arm) begin
      pkt_count <= '0;
    end else if ((state == ST_RUN) && hs && !abort
                 && (pkt_count != '1)) begin
      pkt_count <= pkt_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_vita49_seq_ctrl.sv
// Directed bench for vita49_seq_ctrl: immediate, timed, late, continuous,
// abort, backpressure and mid-run reset scenarios with hand-computed values.
module tb_vita49_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cmd;
  logic        cmd_valid;
  logic [31:0] start_sec;
  logic [63:0] start_fsec;
  logic [31:0] num_pkts;
  logic [31:0] ts_sec;
  logic [63:0] ts_fsec;
  logic [31:0] vita_ctrl;
  logic [31:0] src_cmd;
  logic        src_new_cmd;
  logic [31:0] pkt_count;
  logic [31:0] status;
  logic        done_pulse;

  int n_cmp = 0;
  int n_err = 0;

  vita49_seq_ctrl_if tap ();

  always #5 clk = ~clk;

  vita49_seq_ctrl #(.RST_CYCLES(4)) dut (
    .AXIS_ACLK      (clk),
    .AXIS_ARESETN   (rst_n),
    .cmd            (cmd),
    .cmd_valid      (cmd_valid),
    .start_sec      (start_sec),
    .start_fsec     (start_fsec),
    .num_pkts       (num_pkts),
    .timestamp_sec  (ts_sec),
    .timestamp_fsec (ts_fsec),
    .egress         (tap.slave),
    .vita_ctrl      (vita_ctrl),
    .src_cmd        (src_cmd),
    .src_new_cmd    (src_new_cmd),
    .pkt_count      (pkt_count),
    .status         (status),
    .done_pulse     (done_pulse)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] c);
    cmd       = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd       = '0;
  endtask

  task automatic beat(input logic v, input logic r, input logic l);
    tap.vita_tvalid = v;
    tap.vita_tready = r;
    tap.vita_tlast  = l;
    @(negedge clk);
    tap.vita_tvalid = 1'b0;
    tap.vita_tready = 1'b0;
    tap.vita_tlast  = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    cmd             = '0;
    cmd_valid       = 1'b0;
    start_sec       = '0;
    start_fsec      = '0;
    num_pkts        = '0;
    ts_sec          = '0;
    ts_fsec         = '0;
    tap.vita_tvalid = 1'b0;
    tap.vita_tready = 1'b0;
    tap.vita_tlast  = 1'b0;
    tick(3);
    chk("rst_ctrl", vita_ctrl, 32'h0);
    chk("rst_src", src_cmd, 32'h0);
    chk("rst_strb", {31'd0, src_new_cmd}, 32'h0);
    chk("rst_cnt", pkt_count, 32'h0);
    chk("rst_stat", status, 32'h0);
    chk("rst_done", {31'd0, done_pulse}, 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Immediate run: arm|imm|trl|tsi, 3 packets.
    num_pkts = 32'd3;
    issue(32'h1D);
    chk("imm_rst_ctrl", vita_ctrl, 32'h2);
    chk("imm_rst_src", src_cmd, 32'h2);
    chk("imm_rst_strb", {31'd0, src_new_cmd}, 32'h1);
    chk("imm_rst_stat", status, 32'h9);
    for (int i = 1; i < 4; i++) begin
      tick(1);
      chk("imm_rst_hold", vita_ctrl, 32'h2);
    end
    chk("imm_strb_off", {31'd0, src_new_cmd}, 32'h0);
    tick(1);
    chk("imm_run_ctrl", vita_ctrl, 32'h19);
    chk("imm_run_src", src_cmd, 32'h1);
    chk("imm_run_strb", {31'd0, src_new_cmd}, 32'h1);
    chk("imm_run_stat", status, 32'hB);
    beat(1, 1, 1);
    chk("imm_p1", pkt_count, 32'd1);
    beat(1, 1, 0);
    chk("imm_nolast", pkt_count, 32'd1);
    beat(1, 1, 1);
    chk("imm_p2", pkt_count, 32'd2);
    beat(1, 1, 1);
    chk("imm_p3", pkt_count, 32'd3);
    chk("imm_done_ctrl", vita_ctrl, 32'h0);
    chk("imm_done_pulse", {31'd0, done_pulse}, 32'h1);
    chk("imm_done_src", src_cmd, 32'h0);
    chk("imm_done_strb", {31'd0, src_new_cmd}, 32'h1);
    chk("imm_done_stat", status, 32'h2C);
    tick(1);
    chk("imm_idle_stat", status, 32'h20);
    chk("imm_idle_pulse", {31'd0, done_pulse}, 32'h0);
    chk("imm_idle_cnt", pkt_count, 32'd3);

    // Timed run with passthrough: start (5,100), now (4,0).
    start_sec  = 32'd5;
    start_fsec = 64'd100;
    ts_sec     = 32'd4;
    ts_fsec    = 64'd0;
    num_pkts   = 32'd1;
    issue(32'h21);
    tick(4);
    chk("tim_wait_stat", status, 32'h0A);
    chk("tim_wait_ctrl", vita_ctrl, 32'h0);
    ts_sec  = 32'd5;
    ts_fsec = 64'd99;
    tick(2);
    chk("tim_just_under", status, 32'h0A);
    ts_fsec = 64'd100;
    tick(1);
    chk("tim_cmp_cycle", vita_ctrl, 32'h0);
    tick(1);
    chk("tim_run_ctrl", vita_ctrl, 32'h05);
    chk("tim_run_stat", status, 32'h0B);
    beat(1, 1, 1);
    chk("tim_done_stat", status, 32'h2C);
    chk("tim_done_cnt", pkt_count, 32'd1);
    tick(1);
    chk("tim_idle_stat", status, 32'h20);

    // Late start: start (1,0), now (3,0).
    start_sec  = 32'd1;
    start_fsec = 64'd0;
    ts_sec     = 32'd3;
    ts_fsec    = 64'd0;
    num_pkts   = 32'd2;
    issue(32'h01);
    tick(4);
    chk("late_wait", status, 32'h0A);
    tick(1);
    chk("late_run_stat", status, 32'h1B);
    chk("late_run_ctrl", vita_ctrl, 32'h01);
    issue(32'h1D);
    chk("late_rearm_stat", status, 32'h1B);
    chk("late_rearm_strb", {31'd0, src_new_cmd}, 32'h0);
    issue(32'h00);
    chk("late_nop_stat", status, 32'h1B);
    issue(32'h02);
    chk("late_abort_stat", status, 32'h3C);
    chk("late_abort_pulse", {31'd0, done_pulse}, 32'h1);
    chk("late_abort_cnt", pkt_count, 32'd0);
    tick(1);
    chk("late_idle_stat", status, 32'h30);

    // Continuous run with backpressure and abort.
    num_pkts = 32'd0;
    issue(32'h05);
    tick(4);
    chk("cont_run_ctrl", vita_ctrl, 32'h01);
    chk("cont_run_stat", status, 32'h0B);
    for (int i = 0; i < 9; i++) beat(1, 1, 1);
    chk("cont_9", pkt_count, 32'd9);
    tap.vita_tvalid = 1'b1;
    tap.vita_tlast  = 1'b1;
    tap.vita_tready = 1'b0;
    tick(5);
    chk("bp_stall", pkt_count, 32'd9);
    tap.vita_tready = 1'b1;
    tick(1);
    tap.vita_tvalid = 1'b0;
    tap.vita_tlast  = 1'b0;
    tap.vita_tready = 1'b0;
    chk("bp_hs", pkt_count, 32'd10);
    tick(1);
    chk("bp_hold", pkt_count, 32'd10);
    issue(32'h03);
    chk("cab_stat", status, 32'h2C);
    chk("cab_cnt", pkt_count, 32'd10);
    chk("cab_pulse", {31'd0, done_pulse}, 32'h1);
    chk("cab_src", src_cmd, 32'h0);
    chk("cab_strb", {31'd0, src_new_cmd}, 32'h1);
    tick(1);
    chk("cab_idle", status, 32'h20);
    chk("cab_one_pulse", {31'd0, done_pulse}, 32'h0);
    issue(32'h03);
    chk("idle_armabort_stat", status, 32'h20);
    chk("idle_armabort_strb", {31'd0, src_new_cmd}, 32'h0);
    chk("idle_armabort_cnt", pkt_count, 32'd10);

    // Asynchronous reset during RUN.
    issue(32'h05);
    tick(4);
    beat(1, 1, 1);
    beat(1, 1, 1);
    chk("ar_pre_cnt", pkt_count, 32'd2);
    chk("ar_pre_stat", status, 32'h0B);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ctrl", vita_ctrl, 32'h0);
    chk("ar_src", src_cmd, 32'h0);
    chk("ar_cnt", pkt_count, 32'h0);
    chk("ar_stat", status, 32'h0);
    chk("ar_pulse", {31'd0, done_pulse}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    chk("ar_after_stat", status, 32'h0);
    chk("ar_after_pulse", {31'd0, done_pulse}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vita49_seq_ctrl.md
# vita49_seq_ctrl

Run sequencer for the VITA-49 transmit path. It accepts a software command, pulses reset into `vita49_pack` and the `axis_dsrc_rep` source, and waits for a programmed start timestamp (or starts immediately). It then enables packing with the selected trailer and TSI options, counts emitted packets on the packer's egress stream, and shuts the path down after N packets or on abort. It sits between the AXI-lite register file and the `ctrl` input of `vita49_pack` and the `cmd`/`new_cmd` inputs of `axis_dsrc_rep`.

## Interface
- `RST_CYCLES`, 4: length of the reset pulse in clocks, ≥1.
- `AXIS_ACLK`  in  1  sole clock; all inputs are synchronous to it, including the timestamps.
- `AXIS_ARESETN`  in  1  asynchronous, active-low reset.
- `cmd`  in  32  command fields:
  - [0] arm
  - [1] abort
  - [2] immediate (ignore start time)
  - [3] trailer_en
  - [4] tsi_en
  - [5] passthrough
- `cmd_valid`  in  1  single-cycle strobe that qualifies `cmd`.
- `start_sec`  in  32  start time, integer seconds; sampled at arm.
- `start_fsec`  in  64  start time, fractional part; sampled at arm.
- `num_pkts`  in  32  number of packets to send; 0 means continuous until abort. Sampled at arm.
- `timestamp_sec`  in  32  current time, integer seconds.
- `timestamp_fsec`  in  64  current time, fractional part.
- `vita_tvalid`, `vita_tready`, `vita_tlast`  in  1 each  monitor taps on the packer's M_AXIS.
- `vita_ctrl`  out  32  drives the packer `ctrl`:
  - [0] start
  - [1] reset
  - [2] passthrough
  - [3] trailer_en
  - [4] tsi_en
- `src_cmd`  out  32  source command: 2 = reset, 1 = run, 0 = idle.
- `src_new_cmd`  out  1  single-cycle strobe that qualifies `src_cmd`.
- `pkt_count`  out  32  packets emitted in the current run.
- `status`  out  32  status fields:
  - [2:0] state
  - [3] busy
  - [4] late
  - [5] done (sticky until next arm)
- `done_pulse`  out  1  one-cycle pulse when a run completes or is aborted.

## Operation
- **IDLE**
  - `vita_ctrl` = 0.
  - On `cmd_valid` with arm set: latch start time, `num_pkts` and option bits; clear `pkt_count`, done and late; go to RESET.
- **RESET**
  - Hold `vita_ctrl[1]` = 1 for RST_CYCLES clocks.
  - On entry cycle only: `src_cmd` = 2 and `src_new_cmd` = 1.
  - Then: go to RUN if immediate is set, otherwise go to WAIT.
- **WAIT**
  - Registered 96-bit unsigned compare of {timestamp_sec, timestamp_fsec} ≥ {start_sec, start_fsec}.
  - Go to RUN the cycle after the compare is true.
  - If the compare is already true on the first WAIT cycle, set late and still go to RUN.
- **RUN**
  - `vita_ctrl` = {options, start=1}.
  - On entry cycle only: `src_cmd` = 1 and `src_new_cmd` = 1.
  - `pkt_count` increments on each cycle where `vita_tvalid & vita_tready & vita_tlast` are all high.
  - When `num_pkts` ≠ 0 and the increment reaches `num_pkts`, go to DONE.
- **DONE**
  - One cycle.
  - `vita_ctrl` = 0, `src_cmd` = 0 with `src_new_cmd` = 1, `done_pulse` = 1, done set.
  - Go to IDLE.
- **Abort**
  - `cmd_valid` with abort set, in any state other than IDLE: go to DONE immediately; `pkt_count` holds its value.
  - Abort wins over an arm bit set in the same command.
- Arm while not in IDLE is ignored.
- `cmd_valid` with neither arm nor abort set is ignored.
- `pkt_count` saturates at 2^32−1. With `num_pkts` = 0 it does not wrap.
- State encoding on `status[2:0]`: IDLE = 0, RESET = 1, WAIT = 2, RUN = 3, DONE = 4.

## Timing
- **Reset values:** all outputs 0, state IDLE.
- **Reset mid-run:** asserting `AXIS_ARESETN` low mid-run returns to IDLE asynchronously. No `done_pulse` is produced.
- **Command latency:** `cmd_valid` at cycle t → RESET at t+1, `vita_ctrl[1]` high from t+1 through t+RST_CYCLES.
- **Immediate start:** `vita_ctrl[0]` rises at t+RST_CYCLES+1.
- **Timed start:** `vita_ctrl[0]` rises 2 cycles after the timestamp reaches the start time (1 cycle for the registered compare, 1 for the state change).
- **Last packet:** the TLAST handshake of packet `num_pkts` at cycle u → DONE at u+1 → IDLE with `vita_ctrl` = 0 at u+2.
- **Egress monitoring:** the block only observes egress and never drives `vita_tready`.
- **Status:** `status` and `pkt_count` are registered and update one cycle after the event.

## Structure
- Shared package `vita49_pkg`:
  - state enum
  - `vita_ctrl` bit indices (START, RST, PASS, TRL, TSI)
  - `cmd` bit indices
  - `src_cmd` codes
- Optional sub-module `vita49_time_cmp`: registered 96-bit greater-or-equal comparator, reusable for timed stop or scheduled gating.
- Everything else stays flat in one module.

## Test plan
- **Immediate run:** arm + immediate + trailer_en + tsi_en, `num_pkts` = 3, RST_CYCLES = 4 → `vita_ctrl` = 0x2 for 4 cycles, then 0x19. After the 3rd TLAST: `pkt_count` = 3, `done_pulse`, `vita_ctrl` = 0.
- **Timed run:** start = (5, 100), arm at time (4, 0) → `vita_ctrl[0]` rises exactly 2 cycles after the timestamp reaches (5, 100); late = 0.
- **Late start:** start = (1, 0) with current time (3, 0) → RUN on the first WAIT exit; `status[4]` = 1.
- **Continuous and abort:** `num_pkts` = 0, 10 packets sent, then abort → `pkt_count` = 10, one `done_pulse`, `src_cmd` = 0 strobed. Arm+abort issued in IDLE is ignored.
- **Backpressure:** TLAST held with `vita_tready` = 0 for 5 cycles → count increments only once, on the handshake cycle.
- **Reset during RUN:** `AXIS_ARESETN` low for 1 cycle → all outputs 0 immediately, state IDLE, no `done_pulse`.
